// File: rtl/keyboard_pkg.sv
// Shared PS/2 keyboard constants: prefix bytes, controller status bytes,
// default game key make codes and the scan-code decoder state type.
package keyboard_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam logic [7:0] SC_Z = 8'h1A;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_V = 8'h2A;
  localparam logic [7:0] SC_B = 8'h32;

  // Key 0 sits in the least significant byte.
  localparam logic [39:0] DEFAULT_KEY_CODES = {SC_B, SC_V, SC_C, SC_X, SC_Z};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kb_state_t;

  function automatic logic is_status_code(input logic [7:0] code);
    return (code == SC_ACK) || (code == SC_BAT_OK) ||
           (code == SC_ECHO) || (code == SC_RESEND);
  endfunction

endpackage

// File: rtl/scan_code_match.sv
// Combinational lookup of a scan code in the packed make-code table;
// duplicate table entries resolve to the lowest index.
module scan_code_match #(
  parameter int NUM_KEYS = 5,
  parameter int IDX_W    = $clog2(NUM_KEYS + 1)
) (
  input  logic [7:0]            code,
  input  logic [8*NUM_KEYS-1:0] key_codes,
  output logic                  hit,
  output logic [IDX_W-1:0]      index
);

  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (code == key_codes[8*i +: 8]) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks held/released state of mapped PS/2 keys from the controller byte
// stream, decoding F0/E0 prefixes and emitting one-cycle make/break events.
module ps2_key_tracker
  import keyboard_pkg::*;
#(
  parameter int                    NUM_KEYS       = 5,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = DEFAULT_KEY_CODES,
  parameter int                    TIMEOUT_CYCLES = 50_000_000,
  localparam int                   IDX_W          = $clog2(NUM_KEYS + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_en,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [IDX_W-1:0]    data_out,
  output logic                key_pressed,
  output logic                event_valid,
  output logic                event_make,
  output logic [IDX_W-1:0]    event_index
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  kb_state_t           state, state_nxt;
  logic [CNT_W-1:0]    idle_cnt;
  logic                timeout_hit;
  logic                byte_ok;
  logic                hit;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_1;
  logic [NUM_KEYS-1:0] key_mask;
  logic [NUM_KEYS-1:0] state_clr;
  logic                held;
  logic                do_make;
  logic                do_break;
  logic [IDX_W-1:0]    fallback;

  scan_code_match #(
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_match (
    .code      (rx_data),
    .key_codes (KEY_CODES),
    .hit       (hit),
    .index     (idx)
  );

  // Status bytes are swallowed without touching the decoder state.
  assign byte_ok     = rx_en && !is_status_code(rx_data);
  assign timeout_hit = (state != ST_IDLE) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign idx_1       = idx + IDX_W'(1);
  assign key_mask    = hit ? (NUM_KEYS'(1) << idx) : '0;
  assign held        = |(key_state & key_mask);
  assign state_clr   = key_state & ~key_mask;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (byte_ok) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_BREAK)    state_nxt = ST_BRK;
          else if (rx_data == SC_EXT) state_nxt = ST_EXT;
        end
        ST_BRK:     state_nxt = ST_IDLE;
        ST_EXT:     state_nxt = (rx_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_nxt = ST_IDLE;
        default:    state_nxt = ST_IDLE;
      endcase
    end else if (!rx_en && timeout_hit) begin
      state_nxt = ST_IDLE;
    end
  end

  // Extended-key bytes never reach these paths, so E0 F0 xx cannot release xx.
  always_comb begin
    do_make  = 1'b0;
    do_break = 1'b0;
    if (byte_ok && hit) begin
      if (state == ST_IDLE && !held)
        do_make = 1'b1;
      if (state == ST_BRK && held)
        do_break = 1'b1;
    end
  end

  always_comb begin
    fallback = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (state_clr[i]) fallback = IDX_W'(i + 1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || rx_en || state == ST_IDLE || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_state   <= '0;
      data_out    <= '0;
      key_pressed <= 1'b0;
      event_valid <= 1'b0;
      event_make  <= 1'b0;
      event_index <= '0;
    end else begin
      event_valid <= do_make || do_break;
      if (do_make) begin
        key_state   <= key_state | key_mask;
        data_out    <= idx_1;
        key_pressed <= 1'b1;
        event_make  <= 1'b1;
        event_index <= idx_1;
      end else if (do_break) begin
        key_state   <= state_clr;
        key_pressed <= |state_clr;
        if (data_out == idx_1) data_out <= fallback;
        event_make  <= 1'b0;
        event_index <= idx_1;
      end
    end
  end

endmodule
